// File: rtl/mul_operand_result_seq.sv
// Sequencer around an external combinational signed multiplier: latches operands,
// waits for the product to settle, captures it, then streams low and high words out.
module mul_operand_result_seq #(
    parameter int unsigned BITS          = 32,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [BITS-1:0]   operand_a,
    input  logic [BITS-1:0]   operand_b,
    output logic [BITS-1:0]   mul_a,
    output logic [BITS-1:0]   mul_b,
    input  logic [2*BITS-1:0] mul_product,
    output logic              busy,
    output logic [BITS-1:0]   z_hi,
    output logic [BITS-1:0]   z_lo,
    output logic              res_valid,
    output logic [BITS-1:0]   res_word,
    output logic              res_sel,
    input  logic              res_ready,
    output logic              done
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDriveLo,
        StDriveHi
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BITS-1:0] mul_a_q, mul_a_d;
    logic [BITS-1:0] mul_b_q, mul_b_d;
    logic [BITS-1:0] z_hi_q, z_hi_d;
    logic [BITS-1:0] z_lo_q, z_lo_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        z_hi_d  = z_hi_q;
        z_lo_d  = z_lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mul_a_d = operand_a;
                    mul_b_d = operand_b;
                    cnt_d   = CntInit;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    z_hi_d  = mul_product[2*BITS-1:BITS];
                    z_lo_d  = mul_product[BITS-1:0];
                    state_d = StDriveLo;
                end
            end
            StDriveLo: begin
                if (res_ready) state_d = StDriveHi;
            end
            StDriveHi: begin
                if (res_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            z_hi_q  <= '0;
            z_lo_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            z_hi_q  <= z_hi_d;
            z_lo_q  <= z_lo_d;
            done_q  <= done_d;
        end
    end

    // Handshake outputs come from the state register only, never from inputs.
    always_comb begin
        busy      = 1'b1;
        res_valid = 1'b0;
        res_sel   = 1'b0;
        res_word  = '0;
        unique case (state_q)
            StIdle:    busy = 1'b0;
            StSettle:  ;
            StDriveLo: begin
                res_valid = 1'b1;
                res_word  = z_lo_q;
            end
            StDriveHi: begin
                res_valid = 1'b1;
                res_sel   = 1'b1;
                res_word  = z_hi_q;
            end
            default:   busy = 1'b0;
        endcase
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign z_hi  = z_hi_q;
    assign z_lo  = z_lo_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mul_operand_result_seq.sv
// Scoreboard bench: expected result words are queued at issue time and popped by a
// monitor on every accepted transfer; a second instance covers a longer settle time.
module tb_mul_operand_result_seq;

    logic        clk = 1'b0;
    logic        clr, start, res_ready;
    logic [31:0] operand_a, operand_b;
    logic [31:0] mul_a, mul_b, z_hi, z_lo, res_word;
    logic [63:0] mul_product;
    logic        busy, res_valid, res_sel, done;

    logic        start4, res_ready4;
    logic [31:0] mul_a4, mul_b4, z_hi4, z_lo4, res_word4;
    logic [63:0] mul_product4;
    logic        busy4, res_valid4, res_sel4, done4;

    logic signed [63:0] pa, pb, pa4, pb4;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    // Behavioural signed multiplier standing in for the Booth array.
    assign pa           = {{32{mul_a[31]}}, mul_a};
    assign pb           = {{32{mul_b[31]}}, mul_b};
    assign mul_product  = pa * pb;
    assign pa4          = {{32{mul_a4[31]}}, mul_a4};
    assign pb4          = {{32{mul_b4[31]}}, mul_b4};
    assign mul_product4 = pa4 * pb4;

    mul_operand_result_seq #(.BITS(32), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .clr(clr), .start(start), .operand_a(operand_a), .operand_b(operand_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product), .busy(busy),
        .z_hi(z_hi), .z_lo(z_lo), .res_valid(res_valid), .res_word(res_word),
        .res_sel(res_sel), .res_ready(res_ready), .done(done)
    );

    mul_operand_result_seq #(.BITS(32), .SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .clr(clr), .start(start4), .operand_a(operand_a), .operand_b(operand_b),
        .mul_a(mul_a4), .mul_b(mul_b4), .mul_product(mul_product4), .busy(busy4),
        .z_hi(z_hi4), .z_lo(z_lo4), .res_valid(res_valid4), .res_word(res_word4),
        .res_sel(res_sel4), .res_ready(res_ready4), .done(done4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (done) break;
            tick();
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (res_valid) break;
            tick();
        end
        check("valid_seen", {63'd0, res_valid}, 64'd1);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo);
        exp_q.push_back({1'b0, lo});
        exp_q.push_back({1'b1, hi});
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        wait_done(40);
        check("job_z_hi", {32'd0, z_hi}, {32'd0, hi});
        check("job_z_lo", {32'd0, z_lo}, {32'd0, lo});
    endtask

    // Monitor: every accepted transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!clr && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_transfer: got sel=%0b word=%0h, expected none",
                         res_sel, res_word);
            end else begin
                check("res_transfer", {31'd0, res_sel, res_word}, {31'd0, exp_q.pop_front()});
            end
        end
        if (done) done_cnt++;
    end

    initial begin
        int d0;
        clr = 1'b1; start = 1'b0; res_ready = 1'b0;
        start4 = 1'b0; res_ready4 = 1'b0;
        operand_a = 32'h1111_1111; operand_b = 32'h2222_2222;
        tick(); tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_valid", {63'd0, res_valid}, 64'd0);
        check("rst_zhi_zlo", {z_hi, z_lo}, 64'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        clr = 1'b0;
        tick();

        // 1: 7 * -3 with exact latency
        res_ready = 1'b1;
        operand_a = 32'd7; operand_b = 32'hFFFF_FFFD; start = 1'b1;
        exp_q.push_back({1'b0, 32'hFFFF_FFEB});
        exp_q.push_back({1'b1, 32'hFFFF_FFFF});
        tick();  // E0
        start = 1'b0; operand_a = 32'hDEAD_BEEF; operand_b = 32'h0BAD_F00D;
        check("t1_e0_busy", {63'd0, busy}, 64'd1);
        check("t1_e0_valid", {63'd0, res_valid}, 64'd0);
        tick();  // E1
        check("t1_e1_valid_sel", {62'd0, res_valid, res_sel}, 64'b10);
        check("t1_e1_z", {z_hi, z_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        tick();  // E2
        check("t1_e2_sel", {63'd0, res_sel}, 64'd1);
        tick();  // E3
        check("t1_e3_done_busy", {62'd0, done, busy}, 64'b10);
        tick();
        check("t1_done_pulse_end", {63'd0, done}, 64'd0);

        // 2: corner operands
        run_job(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        tick();
        run_job(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        tick();

        // 3: backpressure on both words
        d0 = done_cnt;
        res_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h0012_3450});
        exp_q.push_back({1'b1, 32'h0000_0000});
        operand_a = 32'h0001_2345; operand_b = 32'h10; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("t3_lo_hold", {31'd0, res_sel, res_word}, {31'd0, 1'b0, 32'h0012_3450});
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_hi_hold", {30'd0, res_valid, res_sel, res_word}, {30'd0, 2'b11, 32'd0});
            tick();
        end
        res_ready = 1'b1;
        wait_done(10);
        tick(); tick(); tick();
        check("t3_one_done", 64'(done_cnt - d0), 64'd1);

        // 4: start while busy is ignored
        d0 = done_cnt;
        res_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd6});
        exp_q.push_back({1'b1, 32'd0});
        operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
        tick();  // E0 -> SETTLE
        operand_a = 32'd9; operand_b = 32'd9;
        tick();  // E1 -> DRIVE_LO, start ignored in SETTLE
        tick();  // start ignored in DRIVE_LO
        start = 1'b0;
        check("t4_mul_ab", {mul_a, mul_b}, {32'd2, 32'd3});
        check("t4_z_lo", {32'd0, z_lo}, 64'd6);
        res_ready = 1'b1;
        wait_done(10);
        tick(); tick(); tick(); tick();
        check("t4_one_done", 64'(done_cnt - d0), 64'd1);
        check("t4_idle", {63'd0, busy}, 64'd0);

        // 5: clear in DRIVE_HI, then a fresh job
        d0 = done_cnt;
        exp_q.push_back({1'b0, 32'd42});
        operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
        tick();  // E0
        start = 1'b0;
        tick();  // E1 DRIVE_LO, low word transferred
        tick();  // E2 DRIVE_HI
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_busy_valid", {62'd0, busy, res_valid}, 64'd0);
        check("t5_z_cleared", {z_hi, z_lo}, 64'd0);
        tick();
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        run_job(32'd4, 32'd5, 32'd0, 32'd20);
        tick();

        // 6: SETTLE_CYCLES=4 instance, latency and back-to-back start
        res_ready = 1'b0;
        operand_a = 32'd3; operand_b = 32'hFFFF_FFFB; start4 = 1'b1;
        tick();  // E0
        start4 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();  // E1..E3
            check("t6_no_capture_yet", {31'd0, res_valid4, z_lo4}, 64'd0);
        end
        tick();  // E4
        check("t6_e4_valid", {63'd0, res_valid4}, 64'd1);
        check("t6_e4_z", {z_hi4, z_lo4}, 64'hFFFF_FFFF_FFFF_FFF1);
        res_ready4 = 1'b1;
        tick();  // E5 DRIVE_HI
        check("t6_hi_word", {31'd0, res_sel4, res_word4}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        tick();  // E6 done cycle
        check("t6_done", {62'd0, done4, busy4}, 64'b10);
        operand_a = 32'd10; operand_b = 32'd10; start4 = 1'b1;
        tick();  // E7 accepted
        start4 = 1'b0;
        check("t6_b2b_busy_done", {62'd0, busy4, done4}, 64'b10);
        check("t6_b2b_mul_ab", {mul_a4, mul_b4}, {32'd10, 32'd10});
        for (int i = 0; i < 4; i++) tick();  // E11 capture
        check("t6_b2b_z", {z_hi4, z_lo4}, 64'd100);
        for (int i = 0; i < 4; i++) tick();
        res_ready4 = 1'b0;

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mul_operand_result_seq.md
Name: mul_operand_result_seq

Overview:
Sequencer wrapped around the combinational signed Booth multiplier.
- Upstream side: latches the two operands (Y register value and bus value) and holds them stable on the multiplier inputs.
- Downstream side: waits for the combinational path to settle, captures the 2*BITS product into the ZHigh/ZLow register pair, then presents ZLow and then ZHigh to the bus, one word at a time, under a valid/ready handshake.

Parameters:
BITS, 32, operand width; product width is 2*BITS.
SETTLE_CYCLES, 1, clock cycles allowed for the multiplier to settle after operands are latched; legal range 1..15.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
clr  in  1  synchronous, active-high reset.
start  in  1  request a multiply; sampled only in IDLE.
operand_a  in  BITS  multiplicand (Y register).
operand_b  in  BITS  multiplier (bus).
mul_a  out  BITS  registered multiplicand driven to the multiplier.
mul_b  out  BITS  registered multiplier driven to the multiplier.
mul_product  in  2*BITS  signed product returned from the multiplier.
busy  out  1  high in every state except IDLE.
z_hi  out  BITS  captured product[2*BITS-1:BITS].
z_lo  out  BITS  captured product[BITS-1:0].
res_valid  out  1  res_word is valid for transfer.
res_word  out  BITS  z_lo while in DRIVE_LO, z_hi while in DRIVE_HI, 0 otherwise.
res_sel  out  1  0 = low word, 1 = high word; 0 outside the drive states.
res_ready  in  1  consumer accepts res_word.
done  out  1  one-cycle pulse when the high word is accepted.

Behaviour:
- Reset (clr=1 at an edge, any state, any priority):
  - State goes to IDLE.
  - mul_a, mul_b, z_hi, z_lo, the settle counter, res_valid, done and busy all go to 0.
  - clr overrides start and res_ready in the same cycle.
- States: IDLE, SETTLE, DRIVE_LO, DRIVE_HI. No separate capture state.
- IDLE:
  - start=1 at an edge: mul_a<=operand_a, mul_b<=operand_b, cnt<=SETTLE_CYCLES-1, next state SETTLE.
  - start=0: stay in IDLE.
- SETTLE:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: z_hi<=mul_product upper half, z_lo<=mul_product lower half, next state DRIVE_LO.
- DRIVE_LO:
  - res_valid=1, res_sel=0, res_word=z_lo.
  - res_ready=1 at an edge: transfer completes, next state DRIVE_HI.
  - res_ready=0: hold; all outputs stable for any number of cycles.
- DRIVE_HI:
  - res_valid=1, res_sel=1, res_word=z_hi.
  - res_ready=1 at an edge: done<=1 for exactly the following cycle, next state IDLE.
- res_valid, res_sel, res_word and busy are decoded from the state register only, with no combinational path from inputs.
- Latency with SETTLE_CYCLES=1, start sampled at edge E0:
  - Product captured at E1; res_valid high from E1.
  - Earliest low-word transfer at E2, high-word transfer at E3.
  - done high during the cycle after E3.
  - General case: capture at edge E0+SETTLE_CYCLES.
- start outside IDLE is ignored: no operand relatch, no queueing.
- A new start is accepted in the cycle where done is high (state is already IDLE).
- mul_a and mul_b hold their values until the next accepted start.
- z_hi and z_lo hold their values until the next capture.
- Product is signed two's complement; no truncation or saturation; z_hi/z_lo is the full 2*BITS result.
- operand_a and operand_b may change freely after the start edge without affecting the result.

Test Plan:
1. Basic signed multiply: start with a=7, b=0xFFFFFFFD (-3), res_ready=1 -> z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB. res_word sequence is 0xFFFFFFEB then 0xFFFFFFFF. done pulses at E3+1.
2. Corner operands: a=b=0x80000000 -> z_hi=0x40000000, z_lo=0x00000000. Then a=0x7FFFFFFF, b=0x7FFFFFFF -> z_hi=0x3FFFFFFF, z_lo=0x00000001.
3. Backpressure: a=0x12345, b=0x10, res_ready=0 for 5 cycles in DRIVE_LO and 3 cycles in DRIVE_HI -> res_word holds 0x00123450, then 0x00000000, stable while stalled. Exactly one done pulse.
4. Start while busy: pulse start with a=9, b=9 during SETTLE and during DRIVE_LO of a 2*3 job -> result is 6; mul_a/mul_b remain 2/3; no second done.
5. Reset mid-operation: assert clr in DRIVE_HI -> next cycle state IDLE, busy=0, res_valid=0, z_hi=z_lo=0, no done. A following start with 4*5 gives z_lo=20.
6. SETTLE_CYCLES=4 build: start at E0 -> z_hi/z_lo captured at E4; res_valid first high after E4; a back-to-back start in the done cycle is accepted.
